regfile_param: RTL
==================

Name: regfile_param

Overview:
Parametrised register file and the successor to the single-bit enable register. It holds DEPTH words of WIDTH bits, each built as an enable-gated D flip-flop bank. It has one synchronous write port and two combinational read ports, for use as the CPU integer register file. Optional features are a hardwired zero register, read-during-write bypass and a synchronous bulk clear.

Parameters:
WIDTH, 64, bits per register
DEPTH, 32, number of registers; must be >= 2
ADDR_W, $clog2(DEPTH), address width; derived, do not override
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read of the address being written returns wr_data in the same cycle

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset; 0 clears every register
clear  input  1  synchronous clear of all registers on the next rising edge
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  WIDTH  read port A data
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  WIDTH  read port B data

Behaviour:
- Reset (reset=0):
  - All registers go to 0 immediately, with no clock needed.
  - rd_data_a and rd_data_b are forced to 0 while reset=0, and bypass is suppressed.
  - Writes and clear are ignored while reset=0.
  - On release, the first write can occur at the first rising edge with reset=1.
- Write:
  - At a rising edge with reset=1, clear=0, wr_en=1 and wr_addr<DEPTH, reg[wr_addr] <= wr_data.
  - All other registers hold, through a per-register enable mux; no clock gating.
  - Write latency is 1 cycle: the new value is visible from the storage path after the edge.
- Out-of-range address (wr_addr>=DEPTH when DEPTH is not a power of 2): the write is dropped with no side effects.
- Read:
  - Purely combinational: rd_data_x = reg[rd_addr_x].
  - rd_addr_x>=DEPTH returns 0.
  - The two ports are independent; the same address on both ports returns identical data.
- ZERO_REG=1:
  - Register 0 is not stored; reads of address 0 return 0.
  - Writes to address 0 are dropped, and bypass never applies to address 0.
- BYPASS=1:
  - Applies when wr_en=1, reset=1, clear=0, rd_addr_x==wr_addr and the address is in range and writable.
  - Then rd_data_x = wr_data combinationally in the same cycle, for either or both ports.
- BYPASS=0: reads return the pre-edge stored value; the written value appears after the edge.
- Clear:
  - clear=1 at a rising edge zeroes all registers.
  - Clear takes priority over a simultaneous write, so the write is lost.
  - Bypass is suppressed while clear=1.
- Reset mid-write: reset asserting between edges zeroes all registers, including the one about to be written; there is no partial update.
- No internal state exists beyond the register array, and there are no multi-cycle operations.

Test Plan:
1. Reset and readback:
   - Stimulus: hold reset=0 for 2 cycles with wr_en=1, wr_addr=5, wr_data=64'hFF. Release reset, then read all addresses on both ports.
   - Required: every read returns 0.
2. Write then read:
   - Stimulus: write reg3=64'hDEAD_BEEF and reg31=64'h1 on consecutive edges. Next cycle set rd_addr_a=3, rd_addr_b=31.
   - Required: rd_data_a=64'hDEAD_BEEF, rd_data_b=64'h1. All other registers still read 0.
3. Zero register:
   - Stimulus: with ZERO_REG=1, write 64'hAAAA to address 0. Read address 0 in the same cycle and the next.
   - Required: both reads return 0.
   - Stimulus: rerun with ZERO_REG=0.
   - Required: the next-cycle read returns 64'hAAAA.
4. Bypass:
   - Stimulus: reg7 holds 64'h11. Drive wr_en=1, wr_addr=7, wr_data=64'h22, rd_addr_a=rd_addr_b=7 in the same cycle.
   - Required: with BYPASS=1, both ports show 64'h22 before the edge. With BYPASS=0, both show 64'h11 before the edge and 64'h22 after.
5. Clear priority:
   - Stimulus: registers 1..4 hold nonzero values. Assert clear=1 together with wr_en=1, wr_addr=2, wr_data=64'h55 for one edge.
   - Required: all registers read 0 afterwards, including reg2.
6. Asynchronous reset mid-cycle:
   - Stimulus: reg9=64'h99. Pull reset low between clock edges.
   - Required: rd_data for address 9 drops to 0 before the next edge.
   - Stimulus: on a DEPTH=20 build, write to address 25.
   - Required: no register changes.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH words of WIDTH bits, one synchronous
// write port and two combinational read ports. Optional hardwired zero
// register and read-during-write bypass. Synchronous bulk clear and
// asynchronous active-low reset both zero the whole array.
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b
);

  // Storage view of every register; register 0 is a constant when hardwired.
  logic [WIDTH-1:0] mem [DEPTH];

  // One-hot select of the writable register addressed by wr_addr. An
  // out-of-range or hardwired-zero address produces an all-zero vector,
  // so such writes are dropped without touching any register.
  logic [DEPTH-1:0] wr_dec;
  logic             wr_live;
  logic             byp_a;
  logic             byp_b;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG && gi == 0) begin : g_zero
        assign wr_dec[gi] = 1'b0;
        assign mem[gi]    = '0;
      end else begin : g_store
        logic [WIDTH-1:0] q;

        assign wr_dec[gi] = (wr_addr == ADDR_W'(gi));
        assign mem[gi]    = q;

        // Enable-gated flop bank: clear wins over a write, otherwise hold.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            q <= '0;
          end else if (clear) begin
            q <= '0;
          end else if (wr_en && wr_dec[gi]) begin
            q <= wr_data;
          end
        end
      end
    end
  endgenerate

  // A write that will actually land this cycle; qualifies the bypass path.
  assign wr_live = wr_en && reset && !clear && (|wr_dec);

  generate
    if (BYPASS) begin : g_byp
      assign byp_a = wr_live && (rd_addr_a == wr_addr);
      assign byp_b = wr_live && (rd_addr_b == wr_addr);
    end else begin : g_nobyp
      assign byp_a = 1'b0;
      assign byp_b = 1'b0;
    end
  endgenerate

  // Port A read mux; unmatched (out-of-range) addresses fall through to 0.
  always_comb begin
    rd_data_a = '0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr_a == ADDR_W'(i)) begin
          rd_data_a = mem[i];
        end
      end
      if (byp_a) begin
        rd_data_a = wr_data;
      end
    end
  end

  // Port B read mux, independent of port A.
  always_comb begin
    rd_data_b = '0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr_b == ADDR_W'(i)) begin
          rd_data_b = mem[i];
        end
      end
      if (byp_b) begin
        rd_data_b = wr_data;
      end
    end
  end

endmodule
